// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-FF synchroniser, 3-sample majority vote, optional parity,
// one or two stop bits, break detection and a single-word holding register with overrun.
module uart_rx_param #(
    parameter int CLK_HZ    = 100_000_000,
    parameter int BAUD      = 1_000_000,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 uart_data,
    input  logic                 rx_ack,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_avail,
    output logic                 overrun,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det,
    output logic                 busy
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] HALF_LOAD = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] FULL_LOAD = TW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

    generate
        if (CLKS_PER_BIT < 8) begin : g_chk_cpb
            $error("uart_rx_param: CLK_HZ/BAUD must be at least 8");
        end
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_db
            $error("uart_rx_param: DATA_BITS must be 5..9");
        end
        if (PARITY < 0 || PARITY > 2) begin : g_chk_par
            $error("uart_rx_param: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_chk_stop
            $error("uart_rx_param: STOP_BITS must be 1 or 2");
        end
    endgenerate

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;

    logic [1:0]           r_sync;
    logic [1:0]           r_hist;
    state_t               r_state;
    logic [TW-1:0]        r_timer;
    logic [BW-1:0]        r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_bit;
    logic                 r_par_err;
    logic                 r_stop_bad;
    logic                 r_stop_second;

    logic w_line;
    logic w_vote;
    logic w_fall;
    logic w_par_err;
    logic w_stop_bad;
    logic w_stop_final;

    // NOTE: synchroniser and vote history reset to the idle level so reset release never looks like a start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= 2'b11;
            r_hist <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], uart_data};
            r_hist <= {r_hist[0], r_sync[1]};
        end
    end

    assign w_line       = r_sync[1];
    assign w_vote       = (w_line & r_hist[0]) | (w_line & r_hist[1]) | (r_hist[0] & r_hist[1]);
    assign w_fall       = r_hist[0] & ~w_line;
    assign w_par_err    = (PARITY == 1) ? ~(^r_shift ^ w_vote) : (^r_shift ^ w_vote);
    assign w_stop_bad   = r_stop_bad | ~w_vote;
    assign w_stop_final = (STOP_BITS == 1) || r_stop_second;
    assign busy         = (r_state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_timer       <= '0;
            r_bit_idx     <= '0;
            r_shift       <= '0;
            r_par_bit     <= 1'b0;
            r_par_err     <= 1'b0;
            r_stop_bad    <= 1'b0;
            r_stop_second <= 1'b0;
            rx_data       <= '0;
            rx_avail      <= 1'b0;
            overrun       <= 1'b0;
            parity_err    <= 1'b0;
            frame_err     <= 1'b0;
            break_det     <= 1'b0;
        end else begin
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            break_det  <= 1'b0;
            if (rx_ack && rx_avail) begin
                rx_avail <= 1'b0;
                overrun  <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_fall) begin
                        r_timer <= HALF_LOAD;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (r_timer == '0) begin
                        if (w_vote) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_timer   <= FULL_LOAD;
                            r_bit_idx <= '0;
                            r_par_bit <= 1'b0;
                            r_par_err <= 1'b0;
                            r_state   <= S_DATA;
                        end
                    end else begin
                        r_timer <= r_timer - TW'(1);
                    end
                end
                S_DATA: begin
                    if (r_timer == '0) begin
                        r_shift   <= {w_vote, r_shift[DATA_BITS-1:1]};
                        r_bit_idx <= r_bit_idx + BW'(1);
                        r_timer   <= FULL_LOAD;
                        if (r_bit_idx == LAST_BIT) begin
                            r_stop_bad    <= 1'b0;
                            r_stop_second <= 1'b0;
                            r_state       <= (PARITY != 0) ? S_PARITY : S_STOP;
                        end
                    end else begin
                        r_timer <= r_timer - TW'(1);
                    end
                end
                S_PARITY: begin
                    if (r_timer == '0) begin
                        r_par_bit <= w_vote;
                        r_par_err <= w_par_err;
                        r_timer   <= FULL_LOAD;
                        r_state   <= S_STOP;
                    end else begin
                        r_timer <= r_timer - TW'(1);
                    end
                end
                S_STOP: begin
                    if (r_timer != '0) begin
                        r_timer <= r_timer - TW'(1);
                    end else if (!w_stop_final) begin
                        r_stop_bad    <= w_stop_bad;
                        r_stop_second <= 1'b1;
                        r_timer       <= FULL_LOAD;
                    end else if (w_stop_bad) begin
                        // An all-zero frame with a low stop bit is a held-low line, not a bad word.
                        if (r_shift == '0 && !r_par_bit) begin
                            break_det <= 1'b1;
                            r_state   <= S_BREAK;
                        end else begin
                            frame_err <= 1'b1;
                            r_state   <= S_IDLE;
                        end
                    end else begin
                        parity_err <= r_par_err;
                        r_state    <= S_IDLE;
                        if (!rx_avail || rx_ack) begin
                            rx_data  <= r_shift;
                            rx_avail <= 1'b1;
                        end else begin
                            overrun <= 1'b1;
                        end
                    end
                end
                S_BREAK: begin
                    if (w_vote) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
